// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin shared 32x32 multiplier controller
//
// Shares one combinational 32x32->64 unsigned multiplier among NREQ issuers.
// A winner is picked round-robin in IDLE, its operands are captured, and the
// product is registered LAT cycles later and held until the consumer takes it.
// Signed operations are handled by sign-magnitude conversion around the core.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   req_valid     per-requester request
//   req_signed    per-requester operand signedness (1 = two's complement)
//   req_a, req_b  packed operands, slot i at [32*i+31:32*i]
//   req_ready     one-hot grant, only ever asserted in IDLE
//   resp_valid    result held for the consumer
//   resp_ready    consumer accepts the result
//   resp_id       index of the requester owning the result
//   resp_hi/lo    product bits [63:32] / [31:0]
//   busy          controller is not idle

module mul_share_mul32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);
  assign p_o = {32'd0, a_i} * {32'd0, b_i};
endmodule

module mul_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_signed,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_hi,
  output logic [31:0]          resp_lo,
  output logic                 busy
);

  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic            sgn_q, sgn_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  // Round-robin pick starting at ptr_q; first valid slot wins.
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            any_req;

  always_comb begin
    logic [IDW-1:0] idx;
    grant   = '0;
    win     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (!any_req && req_valid[idx]) begin
        any_req    = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // One-hot operand mux for the winner.
  logic [31:0] sel_a, sel_b;
  logic        sel_s;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
        sel_s = req_signed[i];
      end
    end
  end

  // Sign-magnitude wrapper around the unsigned core; only the captured
  // operands feed it, so live request buses may change after the handshake.
  logic [31:0] mag_a, mag_b;
  logic [63:0] prod_u, prod;
  logic        neg;

  assign mag_a = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign mag_b = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
  assign neg   = sgn_q && (a_q[31] ^ b_q[31]);

  mul_share_mul32 u_core (
    .a_i (mag_a),
    .b_i (mag_b),
    .p_o (prod_u)
  );

  assign prod = neg ? (~prod_u + 64'd1) : prod_u;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          a_d     = sel_a;
          b_d     = sel_b;
          sgn_d   = sel_s;
          id_d    = win;
          ptr_d   = IDW'((int'(win) + 1) % NREQ);
          cnt_d   = CW'(LAT - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Grant is combinational from req_valid, so it is masked by reset to keep
  // every output at zero while reset is held.
  assign req_ready  = (state_q == IDLE && rst) ? grant : '0;
  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_id    = id_q;
  assign resp_hi    = hi_q;
  assign resp_lo    = lo_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// tb/tb_mul_share_ctrl.sv - self-checking bench for mul_share_ctrl
//
// Bench for the shared multiplier controller: a cycle-level reference model
// of the main instance (LAT=2) plus directed checks, and a second instance
// (LAT=8) for reset during an in-flight operation.

module tb_mul_share_ctrl;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_signed;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [31:0]       resp_hi;
  logic [31:0]       resp_lo;
  logic              busy;

  logic              rst8;
  logic [NREQ-1:0]   v8;
  logic [NREQ-1:0]   s8;
  logic [32*NREQ-1:0] a8;
  logic [32*NREQ-1:0] b8;
  logic [NREQ-1:0]   rdy8;
  logic              rv8;
  logic              rr8;
  logic [IDW-1:0]    id8;
  logic [31:0]       hi8;
  logic [31:0]       lo8;
  logic              busy8;

  mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_hi(resp_hi), .resp_lo(resp_lo), .busy(busy)
  );

  mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .LAT(8)) u_dut8 (
    .clk(clk), .rst(rst8), .req_valid(v8), .req_signed(s8),
    .req_a(a8), .req_b(b8), .req_ready(rdy8),
    .resp_valid(rv8), .resp_ready(rr8), .resp_id(id8),
    .resp_hi(hi8), .resp_lo(lo8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      return 64'(x * y);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: one op outstanding at most; result visible from LAT
  // edges after the grant edge until an edge with resp_ready.
  int          cyc = 0;
  bit          m_out = 1'b0;
  int          m_g = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic [63:0] m_p = '0;

  initial begin
    int w;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_out = 1'b0;
        m_ptr = 0;
        cyc   = 0;
      end else begin
        if (m_out) begin
          if ((cyc - m_g) >= LAT && resp_ready) m_out = 1'b0;
        end else begin
          w = rr_pick(req_valid, m_ptr);
          if (w >= 0) begin
            m_out = 1'b1;
            m_g   = cyc + 1;
            m_id  = w;
            m_p   = ref_mul(req_signed[w], req_a[32*w +: 32], req_b[32*w +: 32]);
            m_ptr = (w + 1) % NREQ;
          end
        end
        cyc++;
      end
    end
  end

  initial begin
    bit exp_rv;
    int w;
    logic [NREQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (chk_en && rst) begin
        exp_rv  = m_out && ((cyc - m_g) >= LAT);
        w       = rr_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (!m_out && w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("resp_valid", 64'(resp_valid), 64'(exp_rv));
        check("busy", 64'(busy), 64'(m_out));
        if (exp_rv) begin
          check("resp_id", 64'(resp_id), 64'(m_id));
          check("resp_prod", {resp_hi, resp_lo}, m_p);
        end
      end
    end
  end

  task automatic run_op(input int slot, input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [NREQ-1:0] rdy, output int lat, output int id,
                        output logic [63:0] p);
    int t;
    @(posedge clk); #1;
    req_valid             = '0;
    req_valid[slot]       = 1'b1;
    req_signed[slot]      = s;
    req_a[32*slot +: 32]  = a;
    req_b[32*slot +: 32]  = b;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[slot] && t < 20);
    rdy = req_ready;
    if (!req_ready[slot]) check("grant_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    req_a = {$urandom, $urandom, $urandom, $urandom};
    req_b = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    id = int'(resp_id);
    p  = {resp_hi, resp_lo};
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 50);
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [NREQ-1:0] rdy;
    int lat, id, ng, t;
    logic [63:0] p;
    int gid[5];
    int gt[5];
    int exp_ids[5] = '{0, 1, 2, 3, 0};

    rst = 1'b0; rst8 = 1'b0;
    req_valid = '1; req_signed = '0; req_a = '1; req_b = '1; resp_ready = 1'b1;
    v8 = '0; s8 = '0; a8 = '0; b8 = '0; rr8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rv", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_id", 64'(resp_id), 64'd0);
    check("rst_prod", {resp_hi, resp_lo}, 64'd0);
    req_valid = '0; req_a = '0; req_b = '0;
    @(negedge clk);
    rst = 1'b1; rst8 = 1'b1; chk_en = 1'b1;

    // Unsigned max operands on slot 2
    run_op(2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rdy, lat, id, p);
    check("t1_ready", 64'(rdy), 64'b0100);
    check("t1_lat", 64'(lat), 64'd2);
    check("t1_id", 64'(id), 64'd2);
    check("t1_prod", p, 64'hFFFF_FFFE_0000_0001);

    // Signed cases on slot 3
    run_op(3, 1'b1, 32'hFFFF_FFFD, 32'd7, rdy, lat, id, p);
    check("t2_neg", p, 64'hFFFF_FFFF_FFFF_FFEB);
    check("t2_id", 64'(id), 64'd3);
    run_op(3, 1'b1, 32'h8000_0000, 32'h8000_0000, rdy, lat, id, p);
    check("t2_minmin_s", p, 64'h4000_0000_0000_0000);
    run_op(3, 1'b0, 32'h8000_0000, 32'h8000_0000, rdy, lat, id, p);
    check("t2_minmin_u", p, 64'h4000_0000_0000_0000);

    // Round robin with all four requesting
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'hF000_0001 + 32'(i) * 32'h1111_1111;
      req_b[32*i +: 32] = 32'h0000_1234 << i;
    end
    req_signed = 4'b0101;
    req_valid  = 4'b1111;
    ng = 0; t = 0;
    while (ng < 5 && t < 100) begin
      @(negedge clk); t++;
      if (req_ready != '0) begin
        gid[ng] = oh_idx(req_ready);
        gt[ng]  = t;
        ng++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    check("t3_count", 64'(ng), 64'd5);
    for (int i = 0; i < 5; i++) if (i < ng) check("t3_order", 64'(gid[i]), 64'(exp_ids[i]));
    for (int i = 0; i < 4; i++) if (i + 1 < ng) check("t3_spacing", 64'(gt[i+1] - gt[i]), 64'd4);
    wait_idle();

    // Pointer skip: ptr=1, only slot 3 requests, then everyone
    run_op(3, 1'b0, 32'd100, 32'd200, rdy, lat, id, p);
    check("t4_id", 64'(id), 64'd3);
    check("t4_prod", p, 64'd20000);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("t4_wrap", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();

    // Backpressure on slot 1, another requester waiting
    resp_ready = 1'b0;
    run_op(1, 1'b1, 32'hFFFF_FFFF, 32'd2, rdy, lat, id, p);
    req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_rv", 64'(resp_valid), 64'd1);
      check("t5_prod", {resp_hi, resp_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      check("t5_id", 64'(resp_id), 64'd1);
      check("t5_ready", 64'(req_ready), 64'd0);
      check("t5_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid  = '0;
    @(posedge clk); #1;
    check("t5_rel_busy", 64'(busy), 64'd0);
    check("t5_rel_rv", 64'(resp_valid), 64'd0);

    // Reset mid-CALC on the LAT=8 instance
    @(posedge clk); #1;
    v8 = 4'b0010; a8[32 +: 32] = 32'd5; b8[32 +: 32] = 32'd6;
    @(negedge clk);
    check("t6_grant", 64'(rdy8), 64'b0010);
    @(posedge clk); #1;
    v8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_pre", 64'(busy8), 64'd1);
    rst8 = 1'b0;
    #1;
    check("t6_rst_ready", 64'(rdy8), 64'd0);
    check("t6_rst_rv", 64'(rv8), 64'd0);
    check("t6_rst_busy", 64'(busy8), 64'd0);
    check("t6_rst_id", 64'(id8), 64'd0);
    check("t6_rst_prod", {hi8, lo8}, 64'd0);
    @(negedge clk);
    rst8 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t6_no_stale_rv", 64'(rv8), 64'd0);
      check("t6_idle", 64'(busy8), 64'd0);
    end
    @(posedge clk); #1;
    v8 = 4'b1111;
    a8[0 +: 32] = 32'd3; b8[0 +: 32] = 32'd4;
    @(negedge clk);
    check("t6_ptr0", 64'(rdy8), 64'b0001);
    @(posedge clk); #1;
    v8 = '0;
    lat = 0;
    while (!rv8 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("t6_lat", 64'(lat), 64'd8);
    check("t6_id", 64'(id8), 64'd0);
    check("t6_prod", {hi8, lo8}, 64'd12);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
